// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, register-select, opcode/funct and ID/EX types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;
  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;
  typedef struct packed {
    logic       valid;
    word_t      pc4;
    word_t      rdat1;
    word_t      rdat2;
    word_t      imm;
    logic [4:0] shamt;
    logic [5:0] opcode;
    logic [5:0] funct;
    regbits_t   rs;
    regbits_t   rt;
    regbits_t   wsel;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
  } idex_t;
  localparam regbits_t LINK_REG = 5'd31;
  // I-type ALU opcodes occupy 6'h08..6'h0F
  function automatic logic is_itype_alu(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction
endpackage

// File: rtl/imm_extender.sv
// imm_extender: widens the 16-bit immediate by opcode (zero, sign or LUI shift)
module imm_extender
  import cpu_types_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [15:0] imm16,
  output word_t       imm
);
  // logical immediates zero-extend, LUI shifts up, everything else sign-extends
  always_comb
    imm = (opcode == OP_LUI) ? {imm16, 16'h0000} :
          (opcode inside {OP_ANDI, OP_ORI, OP_XORI}) ? {16'h0000, imm16} :
          {{16{imm16[15]}}, imm16};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage with load-use detection and the ID/EX pipeline register
module decode_stage
  import cpu_types_pkg::*;
#(
  parameter logic [5:0] HALT_OP     = 6'h3F,
  parameter bit         LU_STALL_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       if_valid,
  input  word_t      if_instr,
  input  word_t      if_pc4,
  output regbits_t   rsel1,
  output regbits_t   rsel2,
  input  word_t      rdat1,
  input  word_t      rdat2,
  input  logic       ex_ready,
  input  logic       flush,
  output logic       stall_id,
  output logic       idex_valid,
  output word_t      idex_pc4,
  output word_t      idex_rdat1,
  output word_t      idex_rdat2,
  output word_t      idex_imm,
  output logic [4:0] idex_shamt,
  output logic [5:0] idex_opcode,
  output logic [5:0] idex_funct,
  output regbits_t   idex_rs,
  output regbits_t   idex_rt,
  output regbits_t   idex_wsel,
  output logic       idex_regwrite,
  output logic       idex_memread,
  output logic       idex_memwrite,
  output logic       halt
);
  logic [5:0] op, fn;
  regbits_t   rs, rt, rd, wsel;
  word_t      imm;
  logic       is_r, is_ld, is_st, is_ialu, is_jal, wr_raw, uses_rt, lu, load_new;
  idex_t      q, d;
  assign op       = if_instr[31:26];
  assign rs       = if_instr[25:21];
  assign rt       = if_instr[20:16];
  assign rd       = if_instr[15:11];
  assign fn       = if_instr[5:0];
  assign rsel1    = rs;
  assign rsel2    = rt;
  assign is_r     = op == OP_RTYPE;
  assign is_ld    = op == OP_LW;
  assign is_st    = op == OP_SW;
  assign is_jal   = op == OP_JAL;
  assign is_ialu  = is_itype_alu(op);
  assign uses_rt  = is_r | is_st | (op == OP_BEQ) | (op == OP_BNE);
  imm_extender u_imm (
    .opcode (op),
    .imm16  (if_instr[15:0]),
    .imm    (imm)
  );
  // destination select and raw write enable; $0 writes are suppressed below
  always_comb begin
    wsel   = is_r ? rd : is_jal ? LINK_REG : (is_ld | is_ialu) ? rt : '0;
    wr_raw = (is_r & (fn != FN_JR)) | is_ld | is_ialu | is_jal;
  end
  // load-use: the load in ID/EX produces a register this instruction reads
  always_comb
    lu = LU_STALL_EN & if_valid & q.valid & q.memread & (q.wsel != '0) &
         ((q.wsel == rs) | (uses_rt & (q.wsel == rt)));
  // flush wins and never stalls; otherwise any hold or bubble holds IF/ID too
  always_comb begin
    stall_id = !flush & (!ex_ready | halt | lu);
    load_new = !flush & ex_ready & !halt & !lu;
  end
  // assemble the next ID/EX entry from the decoded fields
  always_comb begin
    d          = '0;
    d.valid    = if_valid;
    d.pc4      = if_pc4;
    d.rdat1    = rdat1;
    d.rdat2    = rdat2;
    d.imm      = imm;
    d.shamt    = if_instr[10:6];
    d.opcode   = op;
    d.funct    = fn;
    d.rs       = rs;
    d.rt       = rt;
    d.wsel     = wsel;
    d.regwrite = wr_raw & (wsel != '0);
    d.memread  = is_ld;
    d.memwrite = is_st;
  end
  // ID/EX register: bubble on flush/halt/load-use, hold when execute is busy
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      q    <= '0;
      halt <= 1'b0;
    end else if (flush) begin
      q    <= '0;
    end else if (ex_ready) begin
      q    <= load_new ? d : '0;
      halt <= halt | (load_new & if_valid & (op == HALT_OP));
    end
  assign idex_valid    = q.valid;
  assign idex_pc4      = q.pc4;
  assign idex_rdat1    = q.rdat1;
  assign idex_rdat2    = q.rdat2;
  assign idex_imm      = q.imm;
  assign idex_shamt    = q.shamt;
  assign idex_opcode   = q.opcode;
  assign idex_funct    = q.funct;
  assign idex_rs       = q.rs;
  assign idex_rt       = q.rt;
  assign idex_wsel     = q.wsel;
  assign idex_regwrite = q.regwrite;
  assign idex_memread  = q.memread;
  assign idex_memwrite = q.memwrite;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode checks plus load-use, flush/stall, halt and reset sequences
module tb_decode_stage;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        if_valid = 1'b0, ex_ready = 1'b1, flush = 1'b0;
  logic [31:0] if_instr = '0, if_pc4 = '0, rdat1 = '0, rdat2 = '0;
  logic [4:0]  rsel1, rsel2, idex_shamt, idex_rs, idex_rt, idex_wsel;
  logic [5:0]  idex_opcode, idex_funct;
  logic [31:0] idex_pc4, idex_rdat1, idex_rdat2, idex_imm;
  logic        stall_id, idex_valid, idex_regwrite, idex_memread, idex_memwrite, halt;
  int n_vec = 0, n_bad = 0;

  decode_stage dut (
    .CLK(CLK), .nRST(nRST), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
    .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2), .ex_ready(ex_ready),
    .flush(flush), .stall_id(stall_id), .idex_valid(idex_valid), .idex_pc4(idex_pc4),
    .idex_rdat1(idex_rdat1), .idex_rdat2(idex_rdat2), .idex_imm(idex_imm),
    .idex_shamt(idex_shamt), .idex_opcode(idex_opcode), .idex_funct(idex_funct),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_wsel(idex_wsel),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .idex_memwrite(idex_memwrite), .halt(halt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wsel;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] imm;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    if_valid = v;
    if_instr = ins;
    rdat1    = r1;
    rdat2    = r2;
    if_pc4   = if_pc4 + 32'd4;
  endtask

  initial begin
    vt[0]  = '{32'h00221821, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 32'h00001821};
    vt[1]  = '{32'h3404FFFF, 32'h11, 32'h22, 5'd0, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0000FFFF};
    vt[2]  = '{32'h2004FFFF, 32'h33, 32'h44, 5'd0, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF};
    vt[3]  = '{32'h3C071234, 32'h55, 32'h66, 5'd0, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 32'h12340000};
    vt[4]  = '{32'hAC220008, 32'h77, 32'h88, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 32'h00000008};
    vt[5]  = '{32'h03E00008, 32'h99, 32'hAA, 5'd31, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h00000008};
    vt[6]  = '{32'h0C000100, 32'hBB, 32'hCC, 5'd0, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0, 32'h00000100};
    vt[7]  = '{32'h1022FFFF, 32'hDD, 32'hEE, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF};
    vt[8]  = '{32'h00220021, 32'h12, 32'h34, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 32'h00000021};
    vt[9]  = '{32'h31098000, 32'h56, 32'h78, 5'd8, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 32'h00008000};
    vt[10] = '{32'h8C250000, 32'h9A, 32'hBC, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 32'h00000000};

    // reset held from time 0
    #12;
    chk("rst_valid", 32'(idex_valid), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_rdat1", idex_rdat1, 32'd0);
    nRST = 1'b1;
    tick();

    // decode table
    for (int i = 0; i < NV; i++) begin
      put(1'b1, vt[i].instr, vt[i].r1, vt[i].r2);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall_id), 32'd0);
      chk($sformatf("v%0d_rsel1", i), 32'(rsel1), 32'(vt[i].rs));
      chk($sformatf("v%0d_rsel2", i), 32'(rsel2), 32'(vt[i].rt));
      tick();
      chk($sformatf("v%0d_valid", i), 32'(idex_valid), 32'd1);
      chk($sformatf("v%0d_pc4", i), idex_pc4, if_pc4);
      chk($sformatf("v%0d_rdat1", i), idex_rdat1, vt[i].r1);
      chk($sformatf("v%0d_rdat2", i), idex_rdat2, vt[i].r2);
      chk($sformatf("v%0d_imm", i), idex_imm, vt[i].imm);
      chk($sformatf("v%0d_wsel", i), 32'(idex_wsel), 32'(vt[i].wsel));
      chk($sformatf("v%0d_rw", i), 32'(idex_regwrite), 32'(vt[i].rw));
      chk($sformatf("v%0d_mr", i), 32'(idex_memread), 32'(vt[i].mr));
      chk($sformatf("v%0d_mw", i), 32'(idex_memwrite), 32'(vt[i].mw));
      chk($sformatf("v%0d_rs", i), 32'(idex_rs), 32'(vt[i].rs));
      chk($sformatf("v%0d_rt", i), 32'(idex_rt), 32'(vt[i].rt));
    end

    // load-use: LW $5 in ID/EX, ADDU $6,$5,$2 in ID
    put(1'b1, 32'h00A23021, 32'h1111, 32'h2222);
    #1;
    chk("lu_stall1", 32'(stall_id), 32'd1);
    tick();
    chk("lu_bubble", 32'(idex_valid), 32'd0);
    chk("lu_bubble_rw", 32'(idex_regwrite), 32'd0);
    rdat1 = 32'h5555;
    #1;
    chk("lu_stall2", 32'(stall_id), 32'd0);
    tick();
    chk("lu_valid", 32'(idex_valid), 32'd1);
    chk("lu_wsel", 32'(idex_wsel), 32'd6);
    chk("lu_rdat1", idex_rdat1, 32'h5555);

    // store of the loaded register through rt also stalls
    put(1'b1, 32'h8C250000, 32'h0, 32'h0);
    tick();
    put(1'b1, 32'hAC250000, 32'h0, 32'h0);
    #1;
    chk("lu_sw_stall", 32'(stall_id), 32'd1);
    tick();

    // LW $5 then SLL $6,$3,2 (rs=0, rt=3): no hazard
    put(1'b1, 32'h8C250000, 32'h0, 32'h0);
    tick();
    put(1'b1, 32'h00033080, 32'h0, 32'h3);
    #1;
    chk("nolu_stall", 32'(stall_id), 32'd0);
    tick();
    chk("nolu_valid", 32'(idex_valid), 32'd1);
    chk("nolu_shamt", 32'(idex_shamt), 32'd2);

    // flush beats ex_ready=0
    put(1'b1, 32'h00221821, 32'd9, 32'd9);
    flush = 1'b1;
    ex_ready = 1'b0;
    #1;
    chk("fl_stall", 32'(stall_id), 32'd0);
    tick();
    chk("fl_valid", 32'(idex_valid), 32'd0);
    chk("fl_wsel", 32'(idex_wsel), 32'd0);
    chk("fl_rw", 32'(idex_regwrite), 32'd0);
    flush = 1'b0;
    ex_ready = 1'b1;

    // hold: latch ADDU $3, then ex_ready=0 for three cycles
    put(1'b1, 32'h00221821, 32'd5, 32'd7);
    tick();
    ex_ready = 1'b0;
    put(1'b1, 32'h3404FFFF, 32'hAB, 32'hCD);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_stall", c), 32'(stall_id), 32'd1);
      tick();
      chk($sformatf("hold%0d_valid", c), 32'(idex_valid), 32'd1);
      chk($sformatf("hold%0d_wsel", c), 32'(idex_wsel), 32'd3);
      chk($sformatf("hold%0d_rdat1", c), idex_rdat1, 32'd5);
    end
    ex_ready = 1'b1;

    // halt
    put(1'b1, 32'hFC000000, 32'h0, 32'h0);
    #1;
    chk("h_pre_halt", 32'(halt), 32'd0);
    chk("h_pre_stall", 32'(stall_id), 32'd0);
    tick();
    chk("h_valid", 32'(idex_valid), 32'd1);
    chk("h_opcode", 32'(idex_opcode), 32'h3F);
    chk("h_halt", 32'(halt), 32'd1);
    put(1'b1, 32'h00221821, 32'd1, 32'd2);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("h%0d_stall", c), 32'(stall_id), 32'd1);
      tick();
      chk($sformatf("h%0d_valid", c), 32'(idex_valid), 32'd0);
      chk($sformatf("h%0d_halt", c), 32'(halt), 32'd1);
    end

    // asynchronous reset mid-cycle
    #2;
    nRST = 1'b0;
    #1;
    chk("ar_valid", 32'(idex_valid), 32'd0);
    chk("ar_halt", 32'(halt), 32'd0);
    chk("ar_opcode", 32'(idex_opcode), 32'd0);
    chk("ar_stall", 32'(stall_id), 32'd0);
    nRST = 1'b1;
    tick();
    chk("post_valid", 32'(idex_valid), 32'd1);
    chk("post_wsel", 32'(idex_wsel), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
